// File: rtl/adc_disp_pkg.sv
// Shared types, widths and the double-dabble digit adjust for the ADC display formatter.
package adc_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    CONV  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned MV_WIDTH   = 14;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_WIDTH  = 16;
  localparam int unsigned SH_WIDTH   = BCD_WIDTH + MV_WIDTH;
  localparam int unsigned CNT_WIDTH  = 4;

  localparam logic [MV_WIDTH-1:0] MAX_MV = 14'd9999;

  // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_WIDTH-1:0] dabble_adjust(input logic [BCD_WIDTH-1:0] bcd);
    logic [BCD_WIDTH-1:0] res;
    res = bcd;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_display_formatter_bin2bcd_iter.sv
// Iterative binary-to-BCD converter: one double-dabble shift per clock, 14 shifts per value.
module bin2bcd_iter
  import adc_disp_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [MV_WIDTH-1:0]  bin_in,
  output logic                 done_c,
  output logic [BCD_WIDTH-1:0] bcd_out
);

  logic [SH_WIDTH-1:0]  sh_q, sh_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SH_WIDTH-1:0]  adj_c;

  // Load on start, otherwise adjust-and-shift while shifts remain.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    adj_c = {dabble_adjust(sh_q[SH_WIDTH-1:MV_WIDTH]), sh_q[MV_WIDTH-1:0]};
    if (start) begin
      sh_d  = {BCD_WIDTH'(0), bin_in};
      cnt_d = CNT_WIDTH'(MV_WIDTH);
    end else if (cnt_q != '0) begin
      sh_d  = {adj_c[SH_WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  // Shift register and remaining-shift counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  // Final shift is happening this cycle; result is valid from the next cycle.
  assign done_c  = (cnt_q == CNT_WIDTH'(1));
  assign bcd_out = sh_q[SH_WIDTH-1:MV_WIDTH];

endmodule

// File: rtl/adc_display_formatter.sv
// ADC display formatter: scale sample to mV, clamp to 9999, convert to BCD for the display.
// Optional peak-hold display is enabled by defining ADC_DISP_PEAK_HOLD_EN (adds peak_clr).
module adc_display_formatter
  import adc_disp_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 16,
  parameter int unsigned FS_MV    = 3300,
  parameter int unsigned IN_SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  sample_in,
  input  logic                 sample_valid,
`ifdef ADC_DISP_PEAK_HOLD_EN
  input  logic                 peak_clr,
`endif
  output logic [MV_WIDTH-1:0]  mv_out,
  output logic [BCD_WIDTH-1:0] bcd_out,
  output logic                 overrange,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int unsigned PROD_W = IN_WIDTH + MV_WIDTH;

  state_t                 state_q, state_d;
  logic [IN_WIDTH-1:0]    sample_q, sample_d;
  logic                   pend_q, pend_d;
  logic [IN_WIDTH-1:0]    pend_data_q, pend_data_d;
  logic [MV_WIDTH-1:0]    mv_q, mv_d;
  logic                   ovr_q, ovr_d;
  logic [MV_WIDTH-1:0]    mv_out_q, mv_out_d;
  logic [BCD_WIDTH-1:0]   bcd_out_q, bcd_out_d;
  logic                   ovr_out_q, ovr_out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;

  logic [PROD_W-1:0]      scaled_c;
  logic                   over_c;
  logic [MV_WIDTH-1:0]    new_mv_c;
  logic [MV_WIDTH-1:0]    disp_mv_c;
  logic                   disp_ovr_c;
  logic                   conv_start_c;
  logic                   conv_done_c;
  logic [BCD_WIDTH-1:0]   conv_bcd;

  // Full-width multiply, truncating shift and clamp to four digits.
  always_comb begin
    scaled_c = (PROD_W'(sample_q) * PROD_W'(FS_MV)) >> IN_SHIFT;
    over_c   = (scaled_c > PROD_W'(MAX_MV));
    new_mv_c = over_c ? MAX_MV : MV_WIDTH'(scaled_c);
  end

`ifdef ADC_DISP_PEAK_HOLD_EN
  logic [MV_WIDTH-1:0] peak_q, peak_d;
  logic                sticky_q, sticky_d;

  // Peak selection; a clear coinciding with SCALE shows the new value alone.
  always_comb begin
    if (peak_clr) begin
      disp_mv_c  = new_mv_c;
      disp_ovr_c = over_c;
    end else begin
      disp_mv_c  = (new_mv_c > peak_q) ? new_mv_c : peak_q;
      disp_ovr_c = over_c | sticky_q;
    end
    peak_d   = peak_q;
    sticky_d = sticky_q;
    if (state_q == SCALE) begin
      peak_d   = disp_mv_c;
      sticky_d = disp_ovr_c;
    end else if (peak_clr) begin
      peak_d   = '0;
      sticky_d = 1'b0;
    end
  end

  // Peak value and sticky overrange registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      peak_q   <= peak_d;
      sticky_q <= sticky_d;
    end
  end
`else
  // Without peak hold every sample is displayed as scaled.
  always_comb begin
    disp_mv_c  = new_mv_c;
    disp_ovr_c = over_c;
  end
`endif

  // Next-state, pending capture and output register loads.
  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    pend_d       = pend_q;
    pend_data_d  = pend_data_q;
    mv_d         = mv_q;
    ovr_d        = ovr_q;
    mv_out_d     = mv_out_q;
    bcd_out_d    = bcd_out_q;
    ovr_out_d    = ovr_out_q;
    out_valid_d  = 1'b0;
    conv_start_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_valid) begin
          sample_d = sample_in;
          state_d  = SCALE;
        end
      end
      SCALE: begin
        mv_d         = disp_mv_c;
        ovr_d        = disp_ovr_c;
        conv_start_c = 1'b1;
        state_d      = CONV;
        if (sample_valid) begin
          pend_d      = 1'b1;
          pend_data_d = sample_in;
        end
      end
      CONV: begin
        if (conv_done_c) begin
          state_d = DONE;
        end
        if (sample_valid) begin
          pend_d      = 1'b1;
          pend_data_d = sample_in;
        end
      end
      DONE: begin
        mv_out_d    = mv_q;
        bcd_out_d   = conv_bcd;
        ovr_out_d   = ovr_q;
        out_valid_d = 1'b1;
        if (sample_valid) begin
          sample_d = sample_in;
          pend_d   = 1'b0;
          state_d  = SCALE;
        end else if (pend_q) begin
          sample_d = pend_data_q;
          pend_d   = 1'b0;
          state_d  = SCALE;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      mv_q        <= '0;
      ovr_q       <= 1'b0;
      mv_out_q    <= '0;
      bcd_out_q   <= '0;
      ovr_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      mv_q        <= mv_d;
      ovr_q       <= ovr_d;
      mv_out_q    <= mv_out_d;
      bcd_out_q   <= bcd_out_d;
      ovr_out_q   <= ovr_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  bin2bcd_iter u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (conv_start_c),
    .bin_in  (disp_mv_c),
    .done_c  (conv_done_c),
    .bcd_out (conv_bcd)
  );

  assign mv_out    = mv_out_q;
  assign bcd_out   = bcd_out_q;
  assign overrange = ovr_out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
